// File: rtl/e203_wfi_sleep_ctrl.sv
// WFI entry/exit sequencer on the always-on clock: halts the IFU, drains LSU/BIU, gates core clocks, wakes.
// Optional drain abort counter is enabled by defining E203_WFI_DRAIN_TIMEOUT_EN.
module e203_wfi_sleep_ctrl #(
  parameter int unsigned WAKE_DLY = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wfi_req_valid,
  output logic wfi_req_ready,
  input  logic csr_sleepdeep,
  input  logic irq_pending,
  input  logic dbg_req,
  output logic ifu_halt_req,
  input  logic ifu_halt_ack,
  input  logic lsu_idle,
  input  logic biu_idle,
  output logic core_wfi,
  output logic core_sleep_val,
  output logic drain_timeout
);

`ifdef E203_WFI_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DLY);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DRAIN,
    S_SLEEP,
    S_WAKE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             deep_q;
  logic             wake;

  assign wake = irq_pending | dbg_req;

  // Ready is masked by rst_n so it drops the instant reset asserts, even for the IDLE NOP path.
  assign wfi_req_ready = rst_n &
                         (((state == S_IDLE) & wfi_req_valid & wake) |
                          ((state == S_WAKE) & (cnt == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      deep_q         <= 1'b0;
      ifu_halt_req   <= 1'b0;
      core_wfi       <= 1'b0;
      core_sleep_val <= 1'b0;
      drain_timeout  <= 1'b0;
    end else begin
      drain_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wfi_req_valid && !wake) begin
            state        <= S_HALT;
            deep_q       <= csr_sleepdeep;
            ifu_halt_req <= 1'b1;
          end
        end
        S_HALT: begin
          if (wake) begin
            state <= S_WAKE;
            cnt   <= WAKE_LD;
          end else if (ifu_halt_ack) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end
        end
        S_DRAIN: begin
          // Wake takes priority over the idle condition so SLEEP is never entered with a wake pending.
          if (wake) begin
            state <= S_WAKE;
            cnt   <= WAKE_LD;
          end else if (lsu_idle && biu_idle) begin
            state          <= S_SLEEP;
            core_wfi       <= 1'b1;
            core_sleep_val <= deep_q;
          end else if (TO_EN) begin
            if (cnt == TO_LAST) begin
              state         <= S_WAKE;
              cnt           <= WAKE_LD;
              drain_timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_SLEEP: begin
          if (wake) begin
            state          <= S_WAKE;
            core_wfi       <= 1'b0;
            core_sleep_val <= 1'b0;
            cnt            <= WAKE_LD;
          end
        end
        S_WAKE: begin
          if (cnt == '0) begin
            state        <= S_IDLE;
            ifu_halt_req <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e203_wfi_sleep_ctrl.sv
// Scoreboard bench for e203_wfi_sleep_ctrl: expected ready/timeout cycles are queued at stimulus time.
module tb_e203_wfi_sleep_ctrl;
  localparam int WAKE_DLY = 2;
  localparam int TIMEOUT  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wfi_req_valid = 1'b0;
  logic wfi_req_ready;
  logic csr_sleepdeep = 1'b0;
  logic irq_pending = 1'b0;
  logic dbg_req = 1'b0;
  logic ifu_halt_req;
  logic ifu_halt_ack = 1'b0;
  logic lsu_idle = 1'b0;
  logic biu_idle = 1'b0;
  logic core_wfi;
  logic core_sleep_val;
  logic drain_timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_q[$];
  int to_q[$];
  bit saw_wfi = 1'b0;
  bit prev_v = 1'b0;
  bit prev_r = 1'b0;
  bit prev_rst = 1'b0;

  e203_wfi_sleep_ctrl #(
    .WAKE_DLY(WAKE_DLY),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wfi_req_valid (wfi_req_valid),
    .wfi_req_ready (wfi_req_ready),
    .csr_sleepdeep (csr_sleepdeep),
    .irq_pending   (irq_pending),
    .dbg_req       (dbg_req),
    .ifu_halt_req  (ifu_halt_req),
    .ifu_halt_ack  (ifu_halt_ack),
    .lsu_idle      (lsu_idle),
    .biu_idle      (biu_idle),
    .core_wfi      (core_wfi),
    .core_sleep_val(core_sleep_val),
    .drain_timeout (drain_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard when the DUT raises ready or drain_timeout.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wfi_req_ready) begin
        if (rdy_q.size() == 0) chk("ready_unexpected", int'(wfi_req_ready), 0);
        else chk("ready_cyc", cyc, rdy_q.pop_front());
      end
      if (drain_timeout) begin
        if (to_q.size() == 0) chk("timeout_unexpected", int'(drain_timeout), 0);
        else chk("timeout_cyc", cyc, to_q.pop_front());
      end
      if (core_wfi) saw_wfi = 1'b1;
      if (prev_rst && prev_v && !prev_r && !wfi_req_valid)
        chk("valid_hold", int'(wfi_req_valid), 1);
    end
    prev_v   = wfi_req_valid;
    prev_r   = wfi_req_ready;
    prev_rst = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rdy_q.size() == 0) break;
      n++;
      if (n >= budget) begin
        chk("wait_budget", rdy_q.size(), 0);
        rdy_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
    wfi_req_valid = 1'b0;
    irq_pending   = 1'b0;
    dbg_req       = 1'b0;
    ifu_halt_ack  = 1'b0;
    lsu_idle      = 1'b0;
    biu_idle      = 1'b0;
    csr_sleepdeep = 1'b0;
    chk("halt_clr", int'(ifu_halt_req), 0);
  endtask

  task automatic sleep_cycle(input int ack_wait, input int idle_wait, input int sleep_len,
                             input bit use_dbg, input bit deep, input bit toggle);
    csr_sleepdeep = deep;
    wfi_req_valid = 1'b1;
    tick();
    chk("halt_req_set", int'(ifu_halt_req), 1);
    chk("wfi_in_halt", int'(core_wfi), 0);
    repeat (ack_wait - 1) tick();
    ifu_halt_ack = 1'b1;
    tick();
    chk("wfi_in_drain", int'(core_wfi), 0);
    repeat (idle_wait - 1) tick();
    lsu_idle = 1'b1;
    biu_idle = 1'b1;
    tick();
    chk("wfi_set", int'(core_wfi), 1);
    chk("sleep_val", int'(core_sleep_val), int'(deep));
    if (toggle) csr_sleepdeep = ~deep;
    for (int i = 0; i < sleep_len; i++) begin
      tick();
      chk("wfi_hold", int'(core_wfi), 1);
      chk("sleep_val_hold", int'(core_sleep_val), int'(deep));
    end
    if (use_dbg) dbg_req = 1'b1;
    else irq_pending = 1'b1;
    rdy_q.push_back(cyc + 1 + WAKE_DLY);
    tick();
    chk("wfi_clr", int'(core_wfi), 0);
    chk("sleep_val_clr", int'(core_sleep_val), 0);
    chk("halt_in_wake", int'(ifu_halt_req), 1);
    wait_ready(WAKE_DLY + 8);
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_ready", int'(wfi_req_ready), 0);
    chk("rst_halt", int'(ifu_halt_req), 0);
    chk("rst_wfi", int'(core_wfi), 0);
    chk("rst_sleep_val", int'(core_sleep_val), 0);
    chk("rst_timeout", int'(drain_timeout), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: WFI with interrupt already pending behaves as a NOP
    saw_wfi = 1'b0;
    wfi_req_valid = 1'b1;
    irq_pending   = 1'b1;
    rdy_q.push_back(cyc);
    wait_ready(4);
    chk("t1_no_wfi", int'(saw_wfi), 0);
    tick();

    // 2: full sleep and irq wake
    sleep_cycle(3, 2, 3, 1'b0, 1'b0, 1'b0);
    tick();

    // 3: dbg_req and drain-idle in the same DRAIN cycle
    saw_wfi = 1'b0;
    wfi_req_valid = 1'b1;
    tick();
    ifu_halt_ack = 1'b1;
    tick();
    dbg_req  = 1'b1;
    lsu_idle = 1'b1;
    biu_idle = 1'b1;
    rdy_q.push_back(cyc + 1 + WAKE_DLY);
    wait_ready(WAKE_DLY + 8);
    chk("t3_no_wfi", int'(saw_wfi), 0);
    tick();

    // 4: deep-sleep bit latched at entry, toggled during SLEEP, dbg wake
    sleep_cycle(1, 1, 4, 1'b1, 1'b1, 1'b1);
    tick();

    // 5: DRAIN with biu stuck busy
    wfi_req_valid = 1'b1;
    tick();
    ifu_halt_ack = 1'b1;
    tick();
    lsu_idle = 1'b1;
    biu_idle = 1'b0;
`ifdef E203_WFI_DRAIN_TIMEOUT_EN
    to_q.push_back(cyc + TIMEOUT);
    rdy_q.push_back(cyc + TIMEOUT + WAKE_DLY);
    wait_ready(TIMEOUT + WAKE_DLY + 8);
`else
    repeat (TIMEOUT + 4) tick();
    chk("drain_hold_wfi", int'(core_wfi), 0);
    chk("drain_hold_halt", int'(ifu_halt_req), 1);
    dbg_req = 1'b1;
    rdy_q.push_back(cyc + 1 + WAKE_DLY);
    wait_ready(WAKE_DLY + 8);
`endif
    chk("t5_to_q_empty", to_q.size(), 0);
    tick();

    // 6: asynchronous reset while in SLEEP
    wfi_req_valid = 1'b1;
    tick();
    ifu_halt_ack = 1'b1;
    tick();
    lsu_idle = 1'b1;
    biu_idle = 1'b1;
    tick();
    tick();
    chk("t6_wfi_set", int'(core_wfi), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wfi", int'(core_wfi), 0);
    chk("t6_rst_halt", int'(ifu_halt_req), 0);
    chk("t6_rst_ready", int'(wfi_req_ready), 0);
    chk("t6_rst_sleep_val", int'(core_sleep_val), 0);
    wfi_req_valid = 1'b0;
    ifu_halt_ack  = 1'b0;
    lsu_idle      = 1'b0;
    biu_idle      = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_wfi", int'(core_wfi), 0);
    wfi_req_valid = 1'b1;
    irq_pending   = 1'b1;
    rdy_q.push_back(cyc);
    wait_ready(4);
    tick();

    chk("rdy_q_empty", rdy_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
